inv_matrix: RTL

INV_MATRIX -- requirements
Module: inv_matrix

---
 rtl/inv_matrix.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/inv_matrix.sv
// 2x2 signed matrix inverse in Q4.10 using restoring division on magnitudes.
// Define INV_MATRIX_PAR_DIV_EN for four parallel dividers; otherwise one shared divider runs serially.
module inv_matrix (
  input  logic                clk,
  input  logic                rst,
  input  logic                IN_VALID,
  input  logic signed [3:0]   IN,
  output logic                OUT_VALID,
  output logic signed [13:0]  OUT
);

  localparam int unsigned EW   = 4;
  localparam int unsigned FRAC = 10;
  localparam int unsigned NW   = EW + FRAC;
  localparam int unsigned DW   = 9;
  localparam int unsigned VW   = 8;
  localparam logic [3:0]  LAST_BIT = 4'd13;
`ifdef INV_MATRIX_PAR_DIV_EN
  localparam int unsigned NDIV = 4;
`else
  localparam int unsigned NDIV = 1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DET, S_DIV, S_OUT, S_ZERO} state_t;

  state_t               state, state_nxt;
  logic signed [EW-1:0] el [4];
  logic [1:0]           smp_cnt, q_idx;
  logic [3:0]           bit_cnt;
  logic signed [DW-1:0] det, det_c;
  logic signed [DW-1:0] xa, xb, xc, xd;
  logic [VW-1:0]        dmag;
  logic [VW-1:0]        rem  [NDIV];
  logic [NW-1:0]        quo  [NDIV];
  logic [VW+NW-1:0]     step_c [NDIV];
  logic [NW-1:0]        res  [4];
  logic [NW-1:0]        num_c [4];
  logic                 neg_c [4];
  logic                 div_done_c;
  logic                 out_valid_nxt;
  logic [NW-1:0]        out_nxt;

  // Quotient j (e,f,g,h) divides element d,b,c,a respectively.
  function automatic logic [1:0] src_idx(input logic [1:0] j);
    return (j == 2'd0) ? 2'd3 : (j == 2'd3) ? 2'd0 : j;
  endfunction

  function automatic logic [NW-1:0] mag_num(input logic signed [EW-1:0] x);
    logic [EW-1:0] m;
    m = x[EW-1] ? EW'(-x) : EW'(x);
    return {m, FRAC'(0)};
  endfunction

  function automatic logic [VW+NW-1:0] div_step(input logic [VW-1:0] r,
                                                input logic [NW-1:0] q,
                                                input logic [VW-1:0] dv);
    logic [VW:0] trial;
    logic        ge;
    trial = {r, q[NW-1]};
    ge    = (trial >= {1'b0, dv});
    return {(ge ? VW'(trial - {1'b0, dv}) : trial[VW-1:0]), q[NW-2:0], ge};
  endfunction

  function automatic logic [NW-1:0] apply_sign(input logic [NW-1:0] q, input logic neg);
    return neg ? NW'(-q) : q;
  endfunction

  assign xa    = DW'(el[0]);
  assign xb    = DW'(el[1]);
  assign xc    = DW'(el[2]);
  assign xd    = DW'(el[3]);
  assign det_c = xa * xd - xb * xc;
  assign dmag  = det[DW-1] ? VW'(-det) : VW'(det);

  // f and g carry an extra negation on top of sign(N) ^ sign(det).
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      num_c[j] = mag_num(el[src_idx(2'(j))]);
      neg_c[j] = el[src_idx(2'(j))][EW-1] ^ det[DW-1] ^ ((j == 1) || (j == 2));
    end
    for (int i = 0; i < NDIV; i++) begin
      step_c[i] = div_step(rem[i], quo[i], dmag);
    end
  end

`ifdef INV_MATRIX_PAR_DIV_EN
  assign div_done_c = (bit_cnt == LAST_BIT);
`else
  assign div_done_c = (bit_cnt == LAST_BIT) && (q_idx == 2'd3);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (IN_VALID) state_nxt = S_LOAD;
      S_LOAD: if (!IN_VALID) state_nxt = S_IDLE;
              else if (smp_cnt == 2'd3) state_nxt = S_DET;
      S_DET:  state_nxt = (det_c == '0) ? S_ZERO : S_DIV;
      S_DIV:  if (div_done_c) state_nxt = S_OUT;
      S_OUT:  if (q_idx == 2'd3) state_nxt = S_IDLE;
      S_ZERO: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid_nxt = 1'b0;
    out_nxt       = '0;
    if (state == S_OUT) begin
      out_valid_nxt = 1'b1;
      out_nxt       = res[q_idx];
    end else if (state == S_ZERO) begin
      out_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_VALID <= 1'b0;
      OUT       <= '0;
      smp_cnt   <= '0;
      q_idx     <= '0;
      bit_cnt   <= '0;
      det       <= '0;
      for (int j = 0; j < 4; j++) begin
        el[j]  <= '0;
        res[j] <= '0;
      end
      for (int i = 0; i < NDIV; i++) begin
        rem[i] <= '0;
        quo[i] <= '0;
      end
    end else begin
      OUT_VALID <= out_valid_nxt;
      OUT       <= out_nxt;
      case (state)
        S_IDLE: begin
          el[0]   <= IN;
          smp_cnt <= IN_VALID ? 2'd1 : 2'd0;
        end
        S_LOAD: begin
          if (IN_VALID) begin
            el[smp_cnt] <= IN;
            smp_cnt     <= smp_cnt + 2'd1;
          end else begin
            smp_cnt <= '0;
          end
        end
        S_DET: begin
          det     <= det_c;
          bit_cnt <= '0;
          q_idx   <= '0;
          for (int i = 0; i < NDIV; i++) begin
            rem[i] <= '0;
            quo[i] <= num_c[i];
          end
        end
        S_DIV: begin
          bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
          for (int i = 0; i < NDIV; i++) begin
            rem[i] <= step_c[i][VW+NW-1:NW];
            quo[i] <= step_c[i][NW-1:0];
          end
          if (bit_cnt == LAST_BIT) begin
`ifdef INV_MATRIX_PAR_DIV_EN
            for (int i = 0; i < NDIV; i++) begin
              res[i] <= apply_sign(step_c[i][NW-1:0], neg_c[i]);
            end
`else
            // Store this quotient, then reload the shared divider with the next numerator.
            res[q_idx] <= apply_sign(step_c[0][NW-1:0], neg_c[q_idx]);
            q_idx      <= q_idx + 2'd1;
            rem[0]     <= '0;
            quo[0]     <= num_c[q_idx + 2'd1];
`endif
          end
        end
        S_OUT:   q_idx <= q_idx + 2'd1;
        default: ;
      endcase
    end
  end

endmodule
